// File: rtl/md_writeback_buffer.sv
// One-outstanding-request buffer between issue and the iterative mul/div unit, with a one-entry
// writeback register and destination scoreboard. Optional zero-latency bypass: MD_WB_BYPASS_EN.
module md_writeback_buffer #(
   parameter int width_p          = 32,
   parameter int reg_addr_width_p = 5
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        req_v_i,
   output logic                        req_ready_o,
   input  logic [reg_addr_width_p-1:0] req_rd_i,
   input  logic [width_p-1:0]          req_opA_i,
   input  logic [width_p-1:0]          req_opB_i,
   input  logic [2:0]                  req_funct3_i,
   output logic                        md_v_o,
   input  logic                        md_ready_i,
   output logic [width_p-1:0]          md_opA_o,
   output logic [width_p-1:0]          md_opB_o,
   output logic [2:0]                  md_funct3_o,
   input  logic                        md_v_i,
   input  logic [width_p-1:0]          md_result_i,
   output logic                        md_yumi_o,
   output logic                        wb_v_o,
   output logic [reg_addr_width_p-1:0] wb_rd_o,
   output logic [width_p-1:0]          wb_data_o,
   input  logic                        wb_yumi_i,
   input  logic [reg_addr_width_p-1:0] rs1_i,
   input  logic [reg_addr_width_p-1:0] rs2_i,
   output logic                        hazard_o
);

   logic                        pend_v_q, pend_v_d;
   logic [reg_addr_width_p-1:0] pend_rd_q, pend_rd_d;
   logic                        wb_v_q, wb_v_d;
   logic [reg_addr_width_p-1:0] wb_rd_q, wb_rd_d;
   logic [width_p-1:0]          wb_data_q, wb_data_d;

   logic wb_free;
   logic pend_rd_nz;
   logic issue;
   logic capture;
   logic bypass;
   logic rs1_hit, rs2_hit;

   always_comb begin
      md_opA_o    = req_opA_i;
      md_opB_o    = req_opB_i;
      md_funct3_o = req_funct3_i;
      req_ready_o = md_ready_i & ~pend_v_q;
      md_v_o      = req_v_i & ~pend_v_q;
      issue       = req_v_i & req_ready_o;

      pend_rd_nz  = (pend_rd_q != '0);
      wb_free     = ~wb_v_q | wb_yumi_i;
      // x0 results are dropped, so they never need to wait for the writeback slot
      md_yumi_o   = md_v_i & pend_v_q & (wb_free | ~pend_rd_nz);
      capture     = md_yumi_o & pend_rd_nz;

`ifdef MD_WB_BYPASS_EN
      bypass      = ~wb_v_q & pend_rd_nz & md_v_i & pend_v_q;
`else
      bypass      = 1'b0;
`endif

      wb_v_o    = wb_v_q;
      wb_rd_o   = wb_rd_q;
      wb_data_o = wb_data_q;
      if (bypass) begin
         wb_v_o    = 1'b1;
         wb_rd_o   = pend_rd_q;
         wb_data_o = md_result_i;
      end

      rs1_hit  = (rs1_i != '0) & ((pend_v_q & (rs1_i == pend_rd_q)) | (wb_v_q & (rs1_i == wb_rd_q)));
      rs2_hit  = (rs2_i != '0) & ((pend_v_q & (rs2_i == pend_rd_q)) | (wb_v_q & (rs2_i == wb_rd_q)));
      hazard_o = rs1_hit | rs2_hit;
   end

   always_comb begin
      pend_v_d  = pend_v_q;
      pend_rd_d = pend_rd_q;
      wb_v_d    = wb_v_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;

      if (issue) begin
         pend_v_d  = 1'b1;
         pend_rd_d = req_rd_i;
      end else if (md_yumi_o) begin
         pend_v_d  = 1'b0;
      end

      if (wb_yumi_i) begin
         wb_v_d = 1'b0;
      end
      // a bypassed result taken by the arbiter in the same cycle is never stored
      if (capture && !(bypass && wb_yumi_i)) begin
         wb_v_d    = 1'b1;
         wb_rd_d   = pend_rd_q;
         wb_data_d = md_result_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pend_v_q  <= 1'b0;
         pend_rd_q <= '0;
         wb_v_q    <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         pend_v_q  <= pend_v_d;
         pend_rd_q <= pend_rd_d;
         wb_v_q    <= wb_v_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

endmodule

// File: tb/tb_md_writeback_buffer.sv
// Directed plus randomized bench for md_writeback_buffer against a transaction-level model
// (queues of in-flight destinations and held results).
module tb_md_writeback_buffer;

   localparam int W = 32;
   localparam int A = 5;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          req_v_i;
   logic          req_ready_o;
   logic [A-1:0]  req_rd_i;
   logic [W-1:0]  req_opA_i, req_opB_i;
   logic [2:0]    req_funct3_i;
   logic          md_v_o;
   logic          md_ready_i;
   logic [W-1:0]  md_opA_o, md_opB_o;
   logic [2:0]    md_funct3_o;
   logic          md_v_i;
   logic [W-1:0]  md_result_i;
   logic          md_yumi_o;
   logic          wb_v_o;
   logic [A-1:0]  wb_rd_o;
   logic [W-1:0]  wb_data_o;
   logic          wb_yumi_i;
   logic [A-1:0]  rs1_i, rs2_i;
   logic          hazard_o;

   md_writeback_buffer #(.width_p(W), .reg_addr_width_p(A)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_rd_i(req_rd_i),
      .req_opA_i(req_opA_i), .req_opB_i(req_opB_i), .req_funct3_i(req_funct3_i),
      .md_v_o(md_v_o), .md_ready_i(md_ready_i), .md_opA_o(md_opA_o), .md_opB_o(md_opB_o),
      .md_funct3_o(md_funct3_o), .md_v_i(md_v_i), .md_result_i(md_result_i), .md_yumi_o(md_yumi_o),
      .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_yumi_i(wb_yumi_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_pass = 0;

   // model: destinations issued but not yet returned, results waiting for the register file
   logic [A-1:0] m_pend[$];
   logic [A-1:0] m_held_rd[$];
   logic [W-1:0] m_held_data[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic model_busy_hit(input logic [A-1:0] rs);
      logic hit;
      hit = 1'b0;
      if (rs != 0) begin
         foreach (m_pend[i])      if (m_pend[i] == rs)      hit = 1'b1;
         foreach (m_held_rd[i])   if (m_held_rd[i] == rs)   hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic model_yumi();
      logic slot_free;
      if (m_pend.size() == 0 || !md_v_i) return 1'b0;
      slot_free = (m_held_rd.size() == 0) || wb_yumi_i;
      return slot_free || (m_pend[0] == 0);
   endfunction

   function automatic logic model_bypass();
`ifdef MD_WB_BYPASS_EN
      return (m_held_rd.size() == 0) && (m_pend.size() != 0) && (m_pend[0] != 0) && md_v_i;
`else
      return 1'b0;
`endif
   endfunction

   task automatic settle();
      logic e_busy;
      #1;
      e_busy = (m_pend.size() != 0);
      chk("req_ready", req_ready_o, md_ready_i && !e_busy);
      chk("md_v", md_v_o, req_v_i && !e_busy);
      chk("md_opA", md_opA_o, req_opA_i);
      chk("md_opB", md_opB_o, req_opB_i);
      chk("md_funct3", md_funct3_o, req_funct3_i);
      chk("md_yumi", md_yumi_o, model_yumi());
      chk("hazard", hazard_o, model_busy_hit(rs1_i) || model_busy_hit(rs2_i));
      if (model_bypass()) begin
         chk("wb_v_byp", wb_v_o, 1'b1);
         chk("wb_rd_byp", wb_rd_o, m_pend[0]);
         chk("wb_data_byp", wb_data_o, md_result_i);
      end else begin
         chk("wb_v", wb_v_o, m_held_rd.size() != 0);
         if (m_held_rd.size() != 0) begin
            chk("wb_rd", wb_rd_o, m_held_rd[0]);
            chk("wb_data", wb_data_o, m_held_data[0]);
         end
      end
   endtask

   task automatic tick();
      logic         y, byp;
      logic [A-1:0] rd;
      y   = model_yumi();
      byp = model_bypass();
      rd  = (m_pend.size() != 0) ? m_pend[0] : '0;
      if (m_held_rd.size() != 0 && wb_yumi_i) begin
         void'(m_held_rd.pop_front());
         void'(m_held_data.pop_front());
      end
      if (y) begin
         void'(m_pend.pop_front());
         if (rd != 0 && !(byp && wb_yumi_i)) begin
            m_held_rd.push_back(rd);
            m_held_data.push_back(md_result_i);
         end
      end else if (req_v_i && md_ready_i && m_pend.size() == 0) begin
         m_pend.push_back(req_rd_i);
      end
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      req_v_i = 0; req_rd_i = 0; req_opA_i = 0; req_opB_i = 0; req_funct3_i = 0;
      md_ready_i = 1; md_v_i = 0; md_result_i = 0; wb_yumi_i = 0; rs1_i = 0; rs2_i = 0;
   endtask

   task automatic issue(input logic [A-1:0] rd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f3);
      req_v_i = 1; req_rd_i = rd; req_opA_i = a; req_opB_i = b; req_funct3_i = f3; md_ready_i = 1;
      settle();
      tick();
      req_v_i = 0;
   endtask

   initial begin
      idle_inputs();
      reset_n_i = 0;
      @(negedge clk_i);
      settle();
      chk("rst_wb_v", wb_v_o, 1'b0);
      chk("rst_md_yumi", md_yumi_o, 1'b0);
      chk("rst_hazard", hazard_o, 1'b0);
      chk("rst_req_ready", req_ready_o, 1'b1);
      reset_n_i = 1;
      @(negedge clk_i);

      // MUL rd=5, 7*6 returned as 42
      req_v_i = 1; req_rd_i = 5; req_opA_i = 7; req_opB_i = 6; req_funct3_i = 3'd0;
      settle();
      chk("mul_md_v", md_v_o, 1'b1);
      chk("mul_req_ready", req_ready_o, 1'b1);
      tick();
      req_v_i = 0; md_ready_i = 0; md_v_i = 1; md_result_i = 42;
      settle();
      chk("mul_yumi", md_yumi_o, 1'b1);
      tick();
      md_v_i = 0; md_ready_i = 1;
      settle();
      chk("mul_wb_v", wb_v_o, 1'b1);
      chk("mul_wb_rd", wb_rd_o, 5);
      chk("mul_wb_data", wb_data_o, 42);
      wb_yumi_i = 1;
      settle();
      tick();
      wb_yumi_i = 0;

      // rd=3 result held while DIV rd=4 returns 9
      issue(3, 100, 3, 3'd0);
      md_v_i = 1; md_result_i = 11;
      settle();
      tick();
      md_v_i = 0;
      issue(4, 81, 9, 3'd4);
      rs1_i = 4;
      md_v_i = 1; md_result_i = 9;
      settle();
      chk("div_hazard", hazard_o, 1'b1);
      chk("div_blocked", md_yumi_o, 1'b0);
      tick();
      settle();
      chk("div_still_blocked", md_yumi_o, 1'b0);
      chk("div_old_rd", wb_rd_o, 3);
      wb_yumi_i = 1;
      settle();
      chk("div_yumi", md_yumi_o, 1'b1);
      tick();
      md_v_i = 0; wb_yumi_i = 0; rs1_i = 0;
      settle();
      chk("div_wb_rd", wb_rd_o, 4);
      chk("div_wb_data", wb_data_o, 9);
      chk("div_wb_v", wb_v_o, 1'b1);
      wb_yumi_i = 1;
      settle();
      tick();
      wb_yumi_i = 0;

      // x0 destination: consumed immediately, never written back
      issue(0, 5, 5, 3'd0);
      md_v_i = 1; md_result_i = 25;
      settle();
      chk("x0_yumi", md_yumi_o, 1'b1);
      tick();
      md_v_i = 0;
      settle();
      chk("x0_wb_v", wb_v_o, 1'b0);

      // scoreboard on rd=7, plus a second request while busy
      issue(7, 2, 3, 3'd1);
      rs1_i = 7;
      settle();
      chk("hz_rs1", hazard_o, 1'b1);
      rs1_i = 0; rs2_i = 0;
      settle();
      chk("hz_zero", hazard_o, 1'b0);
      req_v_i = 1; req_rd_i = 9;
      settle();
      chk("busy_req_ready", req_ready_o, 1'b0);
      chk("busy_md_v", md_v_o, 1'b0);
      tick();
      req_v_i = 0;
      md_v_i = 1; md_result_i = 6;
      settle();
      tick();
      md_v_i = 0; rs2_i = 7; wb_yumi_i = 1;
      settle();
      chk("hz_held", hazard_o, 1'b1);
      tick();
      wb_yumi_i = 0;
      settle();
      chk("hz_after_wb", hazard_o, 1'b0);
      rs2_i = 0;

      // asynchronous reset with a held result and a pending request
      issue(5, 1, 1, 3'd0);
      md_v_i = 1; md_result_i = 77;
      settle();
      tick();
      md_v_i = 0;
      issue(6, 1, 2, 3'd0);
      rs1_i = 5; rs2_i = 6;
      settle();
      chk("pre_rst_wb_v", wb_v_o, 1'b1);
      #2;
      reset_n_i = 0;
      #1;
      chk("async_wb_v", wb_v_o, 1'b0);
      chk("async_hazard", hazard_o, 1'b0);
      m_pend.delete(); m_held_rd.delete(); m_held_data.delete();
      @(negedge clk_i);
      reset_n_i = 1;
      rs1_i = 0; rs2_i = 0;
      settle();
      tick();

      for (int i = 0; i < 500; i++) begin
         req_v_i      = 1'($urandom_range(0, 1));
         req_rd_i     = A'($urandom_range(0, 7));
         req_opA_i    = $urandom;
         req_opB_i    = $urandom;
         req_funct3_i = 3'($urandom_range(0, 7));
         md_ready_i   = ($urandom_range(0, 3) != 0);
         md_v_i       = 1'($urandom_range(0, 1));
         md_result_i  = $urandom;
         wb_yumi_i    = 1'($urandom_range(0, 1));
         rs1_i        = A'($urandom_range(0, 7));
         rs2_i        = A'($urandom_range(0, 7));
         settle();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
